// File: rtl/vram_word_streamer_pkg.sv
// vram_word_streamer_pkg: shared VRAM geometry constants and streamer state type
package vram_word_streamer_pkg;
  localparam int VRAM_WADDR_W = 13;
  localparam int VRAM_WDATA_W = 16;
  localparam int VRAM_WORDS = 8192;
  typedef enum logic {IDLE, FETCH} state_t;
endpackage

// File: rtl/vram_word_streamer_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n && !flush) assert (!(wr && full && !rd));
  end
endmodule

// File: rtl/vram_word_streamer.sv
// vram_word_streamer: fetches a run of consecutive VRAM words and streams them out under credit-based backpressure
module vram_word_streamer
  import vram_word_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = VRAM_WADDR_W,
  parameter int DATA_W = VRAM_WDATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [DATA_W-1:0] vram_rddata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [ADDR_W-1:0] cur_addr, last_addr;
  logic [ADDR_W:0] issue_cnt, resp_cnt;
  logic inflight, zero_done, fetch, flush, issue, pop, wr, empty, head_last;
  logic [CW-1:0] fifo_count;
  logic [CW:0] used;
  logic [DATA_W:0] head;
  assign fetch = state == FETCH;
  assign flush = fetch && abort;
  // words already owed a FIFO slot: buffered plus the one returning from the RAM this cycle
  assign used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue = fetch && !abort && issue_cnt != '0 && used < (CW+1)'(FIFO_DEPTH);
  assign wr = inflight && !flush;
  assign m_valid = !empty;
  assign pop = m_valid && m_ready && !flush;
  assign head_last = head[DATA_W];
  assign m_data = head[DATA_W-1:0];
  assign m_last = m_valid && head_last;
  assign busy = fetch;
  assign done = zero_done || (fetch && pop && head_last);
  assign vram_addr = issue ? cur_addr : last_addr;
  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .reset_n,
    .flush,
    .wr,
    .wdata({resp_cnt == (ADDR_W+1)'(1), vram_rddata}),
    .rd(pop),
    .rdata(head),
    .empty,
    .count(fifo_count)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cur_addr <= '0;
      last_addr <= '0;
      issue_cnt <= '0;
      resp_cnt <= '0;
      inflight <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      inflight <= issue;
      if (issue) begin
        cur_addr <= cur_addr + 1'b1;
        last_addr <= cur_addr;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (wr) resp_cnt <= resp_cnt - 1'b1;
      if (!fetch && start && !abort) begin
        if (length != '0) begin
          state <= FETCH;
          cur_addr <= start_addr;
          issue_cnt <= length;
          resp_cnt <= length;
        end else zero_done <= 1'b1;
      end else if (flush || (pop && head_last)) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_vram_word_streamer.sv
// tb_vram_word_streamer: directed table-driven and sequence checks of the VRAM word streamer
module tb_vram_word_streamer;
  logic clk = 1'b0;
  logic reset_n, start, abort, busy, done, m_valid, m_ready, m_last;
  logic [12:0] start_addr, vram_addr;
  logic [13:0] length;
  logic [15:0] vram_rddata, m_data;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [12:0] addr;
    logic [13:0] len;
    int period;
    int poke;
    logic [15:0] first;
    logic [15:0] last;
    int words;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  vram_word_streamer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .vram_addr(vram_addr), .vram_rddata(vram_rddata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always_ff @(posedge clk) vram_rddata <= {3'b0, vram_addr} ^ 16'hA5A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input logic [12:0] addr, input logic [13:0] len, input int period, input int poke,
                     output logic [15:0] first, output logic [15:0] last_d, output int nwords);
    int issued, prev_issued, popped, iss0;
    logic [12:0] prev_addr;
    logic [15:0] held, exp_d;
    logic stalled, fin, exp_issue;
    @(negedge clk);
    start = 1'b1; start_addr = addr; length = len; m_ready = 1'b0;
    #1;
    check("start_busy", 32'(busy), 32'd0);
    prev_addr = vram_addr;
    issued = 0; prev_issued = 0; popped = 0; stalled = 1'b0; fin = 1'b0;
    first = '0; last_d = '0; held = '0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == poke) begin
        start = 1'b1; start_addr = 13'h1500; length = 14'd3;
      end else begin
        start = 1'b0; start_addr = addr; length = len;
      end
      m_ready = (cyc % period) == 0;
      #1;
      iss0 = issued;
      exp_issue = issued < int'(len) && (issued - popped) < 4;
      check("issue", 32'(vram_addr != prev_addr), 32'(exp_issue));
      if (vram_addr != prev_addr) begin
        check("issue_addr", 32'(vram_addr), 32'(13'(addr + 13'(issued))));
        issued++;
      end
      check("busy_run", 32'(busy), 32'd1);
      check("valid", 32'(m_valid), 32'((prev_issued - popped) > 0));
      if (m_valid && stalled) check("stable", 32'(m_data), 32'(held));
      if (m_valid && m_ready) begin
        exp_d = {3'b0, 13'(addr + 13'(popped))} ^ 16'hA5A5;
        check("data", 32'(m_data), 32'(exp_d));
        check("last", 32'(m_last), 32'(popped == int'(len) - 1));
        check("done_pop", 32'(done), 32'(popped == int'(len) - 1));
        if (popped == 0) first = m_data;
        last_d = m_data;
        popped++;
        fin = popped == int'(len);
      end else check("done_idle", 32'(done), 32'd0);
      stalled = m_valid && !m_ready;
      held = m_data;
      prev_addr = vram_addr;
      prev_issued = iss0;
    end
    if (!fin) check("run_timeout", 32'(popped), 32'(len));
    @(negedge clk);
    start = 1'b0; m_ready = 1'b0;
    #1;
    check("end_busy", 32'(busy), 32'd0);
    check("end_valid", 32'(m_valid), 32'd0);
    check("end_done", 32'(done), 32'd0);
    nwords = popped;
  endtask

  initial begin
    logic [15:0] f, l;
    int n;
    vecs[0] = '{13'h0100, 14'd4, 1, 0, 16'hA4A5, 16'hA4A6, 4};
    vecs[1] = '{13'h0200, 14'd8, 4, 0, 16'hA7A5, 16'hA7A2, 8};
    vecs[2] = '{13'h1FFE, 14'd4, 1, 0, 16'hBA5B, 16'hA5A4, 4};
    vecs[3] = '{13'h0ABC, 14'd16, 2, 0, 16'hAF19, 16'hAF6E, 16};
    vecs[4] = '{13'h0300, 14'd16, 1, 5, 16'hA6A5, 16'hA6AA, 16};
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    start_addr = '0; length = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_addr", 32'(vram_addr), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run(vecs[i].addr, vecs[i].len, vecs[i].period, vecs[i].poke, f, l, n);
      check("vec_first", 32'(f), 32'(vecs[i].first));
      check("vec_last", 32'(l), 32'(vecs[i].last));
      check("vec_words", 32'(n), 32'(vecs[i].words));
    end
    // zero-length run
    @(negedge clk);
    start = 1'b1; start_addr = 13'h0777; length = '0;
    #1;
    check("zl_done_now", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zl_done", 32'(done), 32'd1);
    check("zl_busy", 32'(busy), 32'd0);
    check("zl_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1;
    check("zl_done_off", 32'(done), 32'd0);
    check("zl_busy2", 32'(busy), 32'd0);
    check("zl_addr_hold", 32'(vram_addr), 32'h030F);
    // abort mid-run with downstream stalled
    @(negedge clk);
    start = 1'b1; start_addr = 13'h0400; length = 14'd32; m_ready = 1'b0;
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0; abort = c == 10;
      #1;
      if (c == 9) check("abort_pre_valid", 32'(m_valid), 32'd1);
    end
    check("abort_done_now", 32'(done), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(vram_addr), 32'h0403);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("abort_quiet", 32'({done, busy, m_valid}), 32'd0);
    end
    run(13'h0000, 14'd2, 1, 0, f, l, n);
    check("post_abort_first", 32'(f), 32'hA5A5);
    check("post_abort_last", 32'(l), 32'hA5A4);
    check("post_abort_words", 32'(n), 32'd2);
    // reset mid-run
    @(negedge clk);
    start = 1'b1; start_addr = 13'h0600; length = 14'd16; m_ready = 1'b1;
    #1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    check("rst_pre_valid", 32'(m_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1; m_ready = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    check("mid_rst_addr", 32'(vram_addr), 32'd0);
    run(13'h0050, 14'd3, 1, 0, f, l, n);
    check("post_rst_first", 32'(f), 32'hA5F5);
    check("post_rst_last", 32'(l), 32'hA5F7);
    check("post_rst_words", 32'(n), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_word_streamer.md
Name: vram_word_streamer

Overview:
- Video-side read engine for the VRAM dual-port memory: drives the 13-bit word address of the video read port and consumes its 16-bit read data.
- On a start command it fetches a run of consecutive words and presents them as a valid/ready stream to downstream video logic (line/tile renderers).
- Absorbs the one-cycle registered RAM read latency and downstream backpressure with a small credit-controlled FIFO, so no word is dropped or duplicated.

Parameters:
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.
- ADDR_W, 13, VRAM word address width.
- DATA_W, 16, VRAM word width.

Ports:
- clk  input  1  system clock; same clock as the VRAM video port.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle command strobe; ignored while busy=1.
- start_addr  input  ADDR_W  first word address, sampled on an accepted start.
- length  input  ADDR_W+1  number of words to fetch, 0..8192, sampled on an accepted start.
- abort  input  1  cancel the current run.
- busy  output  1  high from an accepted start until done or abort completes.
- done  output  1  one-cycle pulse after the final word is accepted downstream.
- vram_addr  output  ADDR_W  word address driven to the VRAM read port.
- vram_rddata  input  DATA_W  VRAM read data, valid exactly 1 cycle after its address.
- m_valid  output  1  stream word available.
- m_ready  input  1  downstream accepts the word when m_valid & m_ready.
- m_data  output  DATA_W  stream word.
- m_last  output  1  marks the final word of the run; qualified by m_valid.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FSM goes to IDLE; the FIFO is emptied; the in-flight flag and counters are cleared.
  - busy=0, done=0, m_valid=0, m_last=0, vram_addr=0.
- FSM state IDLE:
  - start=1 with length>0 latches the address, loads issue_cnt=resp_cnt=length, and enters FETCH; busy=1 from the next cycle.
  - start=1 with length=0 pulses done for 1 cycle on the next cycle; busy stays 0.
- FSM state FETCH, read issue:
  - A read is issued in a cycle when issue_cnt>0 and (fifo_count + inflight + 1) <= FIFO_DEPTH.
  - An issued read drives vram_addr=cur_addr; cur_addr increments and issue_cnt decrements.
  - The address wraps modulo 2^ADDR_W (8191 -> 0).
- Response capture:
  - The inflight register is set in the cycle after each issue.
  - In that cycle vram_rddata is written into the FIFO, with tag last = (resp_cnt==1); resp_cnt then decrements.
  - The credit check guarantees the FIFO never overflows. Overflow is an assertion failure in simulation.
- Throughput: with m_ready held high, one word is delivered per cycle after an initial 2-cycle latency (start to first m_valid).
- Output:
  - m_valid = FIFO not empty.
  - m_data and m_last come from the FIFO head.
  - A pop occurs on m_valid & m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Completion: when the popped word has last=1, the FSM goes to IDLE, done pulses in the same cycle as the pop, and busy drops the next cycle.
- Start while busy is ignored, with no effect on the current run.
- abort=1 in FETCH:
  - Stops issuing reads immediately.
  - Flushes the FIFO and discards any in-flight response.
  - Returns to IDLE next cycle with no done pulse; m_valid=0 from the next cycle.
  - abort in IDLE is a no-op.
  - abort has priority over a simultaneous pop, and over a simultaneous start in IDLE.
- vram_addr holds its last value when no read is issued (the port is always enabled, so reads are harmless).

Decomposition:
- Shared Verilog include holds VRAM_WADDR_W=13, VRAM_WDATA_W=16 and a VRAM_WORDS=8192 constant, for use by the VRAM wrapper and all video fetchers.
- One sub-module: sync_fifo.
  - Parameterised width/depth, single clock, synchronous active-low reset, plus a flush input.
  - Instantiated here with width DATA_W+1 (data plus last tag).
- FSM, counters and credit logic stay in vram_word_streamer.

Test Plan:
- Basic run: start_addr=0x0100, length=4, m_ready=1, VRAM model returns data=addr^0xA5A5.
  - Expected: m_data 0xA4A5, 0xA4A4, 0xA4A7, 0xA4A6 on consecutive cycles.
  - m_last only on the 4th word; done in the same cycle; busy low next cycle.
- Backpressure: length=8, m_ready toggled in a 1-cycle-high / 3-cycle-low pattern.
  - Expected: all 8 words in order, no duplicates.
  - vram_addr issue stalls whenever the FIFO plus in-flight count reaches 4.
  - m_data is stable while stalled.
- Wrap: start_addr=0x1FFE, length=4.
  - Expected: addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 issued; data in that order.
- Zero length and ignored start:
  - length=0: done pulses next cycle, busy never asserts, no m_valid.
  - A second start during a length=16 run is ignored; exactly 16 words are delivered.
- Abort mid-run: length=32, m_ready=0, abort asserted at cycle 10.
  - Expected: next cycle m_valid=0, busy=0, no done pulse.
  - A following start_addr=0x0000, length=2 run delivers only 0x0000 and 0x0001 data.
- Reset mid-run: reset_n=0 for 1 cycle during a length=16 run.
  - Expected: all outputs return to their reset values the next cycle.
  - No stale word appears on a subsequent run.
